ula_8bits_seq: RTL

ULA_8BITS_SEQ -- requirements
Module: ula_8bits_seq

---
 rtl/ula_8bits_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ula_8bits_seq.sv
// 8-bit ALU built from a single 74181-style 4-bit slice, time-multiplexed
// over two cycles (low nibble, then high nibble) under a small FSM.

// Active-high-data 74181 slice: cn and cn4 are active-low carries.
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       a_eq_b
);

  logic [3:0] x_s;
  logic [3:0] y_s;
  logic [4:0] sum_s;

  // Propagate/generate terms; arithmetic is x + y + carry, logic is xnor(x, y)
  always_comb begin
    x_s   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y_s   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {4'b0000, ~cn};
    if (m) begin
      f = ~(x_s ^ y_s);
    end else begin
      f = sum_s[3:0];
    end
    cn4    = ~sum_s[4];
    a_eq_b = &f;
  end

endmodule

module ula_8bits_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;

  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [3:0] s_r;
  logic       m_r;
  logic       c_in_r;
  logic       carry_r;
  logic       eq_lo_r;
  logic [7:0] f_r;
  logic       c_out_r;
  logic       a_eq_b_r;

  logic [3:0] slice_a_s;
  logic [3:0] slice_b_s;
  logic       slice_cn_s;
  logic [3:0] slice_f_s;
  logic       slice_cn4_s;
  logic       slice_eq_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start is only honoured when not busy
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next_s = ST_LOW;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOW:  state_next_s = ST_HIGH;
      ST_HIGH: state_next_s = ST_DONE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode and slice operand multiplexing
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    slice_a_s  = a_r[3:0];
    slice_b_s  = b_r[3:0];
    slice_cn_s = c_in_r;
    case (state_r)
      ST_LOW: begin
        busy = 1'b1;
      end
      ST_HIGH: begin
        busy       = 1'b1;
        slice_a_s  = a_r[7:4];
        slice_b_s  = b_r[7:4];
        slice_cn_s = carry_r;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  ula_74181 u_slice (
    .a      (slice_a_s),
    .b      (slice_b_s),
    .s      (s_r),
    .m      (m_r),
    .cn     (slice_cn_s),
    .f      (slice_f_s),
    .cn4    (slice_cn4_s),
    .a_eq_b (slice_eq_s)
  );

  // Operand capture and nibble-wise result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      s_r      <= 4'h0;
      m_r      <= 1'b0;
      c_in_r   <= 1'b0;
      carry_r  <= 1'b0;
      eq_lo_r  <= 1'b0;
      f_r      <= 8'h00;
      c_out_r  <= 1'b0;
      a_eq_b_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            s_r    <= s;
            m_r    <= m;
            c_in_r <= c_in;
          end
        end
        ST_LOW: begin
          f_r[3:0] <= slice_f_s;
          carry_r  <= slice_cn4_s;
          eq_lo_r  <= slice_eq_s;
        end
        ST_HIGH: begin
          f_r[7:4] <= slice_f_s;
          c_out_r  <= slice_cn4_s;
          a_eq_b_r <= eq_lo_r & slice_eq_s;
        end
        default: begin
          f_r <= f_r;
        end
      endcase
    end
  end

  assign f      = f_r;
  assign c_out  = c_out_r;
  assign a_eq_b = a_eq_b_r;

endmodule
